// File: rtl/dir_pkg.sv
// Shared direction encodings and helpers for the
// direction queue input block.
package dir_pkg;

  localparam int DIR_MAXW = 32;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  // Opposite directions sit in bit pairs (2k+1, 2k).
  function automatic logic [DIR_MAXW-1:0] dir_reverse(
    input logic [DIR_MAXW-1:0] v
  );
    logic [DIR_MAXW-1:0] r;
    r = '0;
    for (int k = 0; k < DIR_MAXW / 2; k++) begin
      r[2*k]   = v[2*k+1];
      r[2*k+1] = v[2*k];
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button synchroniser, stability counter and
// registered press detector.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          warm1;
  logic          warm2;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (sync2 != level_out) && (cnt == LAST);

  // armed stays low until a released level is seen after
  // reset, so a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      warm1      <= 1'b0;
      warm2      <= 1'b0;
      armed      <= 1'b0;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      warm1 <= 1'b1;
      warm2 <= warm1;
      if (warm2 && !sync2) armed <= 1'b1;
      if (sync2 == level_out) begin
        cnt <= '0;
      end else if (flip) begin
        cnt       <= '0;
        level_out <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
      rise_pulse <= flip && sync2 && armed;
    end
  end

endmodule

// File: rtl/direction_queue_input.sv
// Debounced direction buttons feeding a small turn FIFO
// that the game tick drains one entry per step.
module direction_queue_input
  import dir_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int QUEUE_DEPTH     = 2,
  parameter logic [N_BTN-1:0] INIT_DIR = N_BTN'(DIR_RIGHT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_BTN-1:0]               btn,
  input  logic                           tick,
  output logic [N_BTN-1:0]               direction,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] pending,
  output logic                           accepted,
  output logic                           rejected,
  output logic                           overflow
);

  localparam int PW = $clog2(QUEUE_DEPTH + 1);
  localparam int AW = (QUEUE_DEPTH > 1) ?
                      $clog2(QUEUE_DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(QUEUE_DEPTH - 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(QUEUE_DEPTH);

  logic [N_BTN-1:0]    level;
  logic [N_BTN-1:0]    rise;
  logic [N_BTN-1:0]    press;
  logic [N_BTN-1:0]    cand;
  logic [N_BTN-1:0]    mem [QUEUE_DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       tail_ptr;
  logic [N_BTN-1:0]    refd;
  logic [DIR_MAXW-1:0] rev;
  logic                hit;
  logic                bad;
  logic                full;
  logic                pop;
  logic                push;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (btn[i]),
      .level_out (level[i]),
      .rise_pulse(rise[i])
    );
  end

  assign press = rise & level;

  // Ascending scan: the highest set index is written last.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (press[i]) begin
        cand    = '0;
        cand[i] = 1'b1;
      end
    end
  end

  assign tail_ptr = (wr_ptr == '0) ? PTR_LAST
                                   : wr_ptr - 1'b1;
  assign refd = (pending != '0) ? mem[tail_ptr] : direction;
  assign rev  = dir_reverse(DIR_MAXW'(refd));
  assign hit  = |press;
  assign bad  = (cand == refd) ||
                (DIR_MAXW'(cand) == rev);
  assign full = (pending == FULL_CNT);
  assign pop  = tick && (pending != '0);
  assign push = hit && !bad && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      direction <= INIT_DIR;
      pending   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      accepted  <= 1'b0;
      rejected  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      accepted <= push;
      rejected <= hit && bad;
      overflow <= hit && !bad && full && !pop;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        direction <= mem[rd_ptr];
        rd_ptr    <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        pending <= pending + 1'b1;
      end else if (pop && !push) begin
        pending <= pending - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_direction_queue_input.sv
// Bench for direction_queue_input: vector table plus
// event scoreboard and hand-written corner sequences.
module tb_direction_queue_input;
  import dir_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] direction;
  logic [1:0] pending;
  logic       accepted;
  logic       rejected;
  logic       overflow;

  direction_queue_input #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4),
    .QUEUE_DEPTH    (2),
    .INIT_DIR       (DIR_RIGHT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .tick     (tick),
    .direction(direction),
    .pending  (pending),
    .accepted (accepted),
    .rejected (rejected),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] EV_ACC = 3'b100;
  localparam logic [2:0] EV_REJ = 3'b010;
  localparam logic [2:0] EV_OVF = 3'b001;

  typedef struct {
    logic [3:0] b;
    bit         do_tick;
    logic [2:0] ev;
    logic [1:0] pend;
    logic [3:0] dir;
  } vec_t;

  vec_t       vecs [10];
  logic [2:0] sb [$];
  logic [2:0] ev_now;
  bit         mon_en = 1'b0;
  int         compared = 0;
  int         mismatched = 0;
  int         lat;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_press(input logic [3:0] b,
                          input logic [2:0] ev);
    sb.push_back(ev);
    btn = b;
    step(10);
    btn = 4'b0000;
    step(10);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic check_state(input string name,
                             input logic [3:0] dir,
                             input logic [1:0] pend);
    check({name, "_dir"}, 32'(direction), 32'(dir));
    check({name, "_pend"}, 32'(pending), 32'(pend));
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      ev_now = {accepted, rejected, overflow};
      if (ev_now != 3'b000) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: got %b expected none",
                   ev_now);
        end else begin
          check("event", 32'(ev_now), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{4'b0100, 1'b0, EV_REJ, 2'd0, 4'b1000};
    vecs[1] = '{4'b1000, 1'b0, EV_REJ, 2'd0, 4'b1000};
    vecs[2] = '{4'b1100, 1'b0, EV_REJ, 2'd0, 4'b1000};
    vecs[3] = '{4'b0001, 1'b1, EV_ACC, 2'd0, 4'b0001};
    vecs[4] = '{4'b0010, 1'b0, EV_REJ, 2'd0, 4'b0001};
    vecs[5] = '{4'b0001, 1'b0, EV_REJ, 2'd0, 4'b0001};
    vecs[6] = '{4'b1000, 1'b0, EV_ACC, 2'd1, 4'b0001};
    vecs[7] = '{4'b0100, 1'b0, EV_REJ, 2'd1, 4'b0001};
    vecs[8] = '{4'b0010, 1'b0, EV_ACC, 2'd2, 4'b0001};
    vecs[9] = '{4'b0100, 1'b0, EV_OVF, 2'd2, 4'b0001};

    rst = 1'b1;
    step(3);
    check_state("reset", 4'b0001, 2'd0);
    check("reset_pulses",
          32'({accepted, rejected, overflow}), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    repeat (10) begin
      do_tick();
      step(1);
    end
    check_state("idle", 4'b0001, 2'd0);

    repeat (5) begin
      btn = 4'b1000;
      step(3);
      btn = 4'b0000;
      step(1);
    end
    step(12);
    check_state("bounce", 4'b0001, 2'd0);

    sb.push_back(EV_ACC);
    btn = 4'b1000;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (accepted) begin
        lat = c;
        break;
      end
    end
    check("press_latency", 32'(lat), 32'd7);
    check("press_pend", 32'(pending), 32'd1);
    step(9);
    btn = 4'b0000;
    step(10);
    do_tick();
    check_state("first_tick", 4'b1000, 2'd0);

    for (int i = 0; i < 10; i++) begin
      do_press(vecs[i].b, vecs[i].ev);
      if (vecs[i].do_tick) do_tick();
      check_state($sformatf("vec%0d", i),
                  vecs[i].dir, vecs[i].pend);
    end

    do_tick();
    check_state("drain1", 4'b1000, 2'd1);
    do_tick();
    check_state("drain2", 4'b0010, 2'd0);

    do_press(4'b1000, EV_ACC);
    do_press(4'b0010, EV_ACC);
    check_state("refill", 4'b0010, 2'd2);

    sb.push_back(EV_ACC);
    btn = 4'b0100;
    step(6);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("combo_acc", 32'(accepted), 32'd1);
    check_state("combo", 4'b1000, 2'd2);
    step(4);
    btn = 4'b0000;
    step(10);
    do_tick();
    check_state("combo_head", 4'b0010, 2'd1);

    rst = 1'b1;
    step(1);
    check_state("mid_reset", 4'b0001, 2'd0);
    rst = 1'b0;
    step(2);
    do_tick();
    check_state("post_reset", 4'b0001, 2'd0);

    step(2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/direction_queue_input.md
Name: direction_queue_input

Overview:
- Parametrised successor to the single-register direction latch.
- Synchronises and debounces N_BTN direction buttons, then turns each debounced press into a one-cycle event.
- Rejects repeats and 180-degree reversals, and buffers accepted turns in a small FIFO.
- The game-tick logic pops the FIFO one entry per tick, so quick turn combos between ticks are kept, not lost or overwritten.

Parameters:
- N_BTN, 4: number of buttons; must be even. Bit N_BTN-1 has the highest priority (4-button map: 3=up, 2=down, 1=left, 0=right).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to change a debounced level; minimum 1.
- QUEUE_DEPTH, 2: pending-turn FIFO entries; minimum 1.
- INIT_DIR, 4'b0001 (sized N_BTN): one-hot direction loaded at reset.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset
- btn  input  N_BTN  raw asynchronous buttons, active-high
- tick  input  1  one-cycle game-step strobe; pops the FIFO head into direction
- direction  output  N_BTN  current committed one-hot direction
- pending  output  $clog2(QUEUE_DEPTH+1)  FIFO occupancy
- accepted  output  1  one-cycle pulse when a turn is pushed
- rejected  output  1  one-cycle pulse when a press is a repeat or reversal
- overflow  output  1  one-cycle pulse when a valid turn is dropped because the FIFO is full

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - direction = INIT_DIR; pending = 0; FIFO pointers = 0.
  - accepted, rejected, overflow = 0.
  - Synchroniser flops, debounced levels and debounce counters = 0.
  - A button held through reset produces no press until it is released and pressed again.
  - Reset mid-debounce or with a non-empty FIFO discards everything in flight.
- Synchroniser: two flops per button.
- Debounce, per button:
  - The counter increments while the synced level differs from the debounced level, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles has no effect.
- Press event: registered rising edge of the debounced level; lasts one cycle.
- Arbitration: if several events occur in the same cycle, the highest index wins. The others are silently dropped, with no rejected pulse.
- Reference direction ref = FIFO tail entry if pending > 0, else direction.
- Rule for a candidate c:
  - If c == ref or c == rev(ref) → rejected pulse. rev swaps bit pairs (2k+1, 2k).
  - Otherwise, if the FIFO is not full, or is full with a pop in the same cycle → push and accepted pulse.
  - Otherwise → overflow pulse, nothing stored.
- Pop: on tick with pending > 0, direction <= head and the head is removed the same edge. On tick with the FIFO empty, direction holds. A non-tick cycle never changes direction.
- Simultaneous push and pop:
  - Both occur; pending is unchanged.
  - ref is evaluated from the pre-edge state.
  - When pending == 1, the candidate is checked against the entry being popped.
- Latency from raw btn rising at cycle 0 and held:
  - Synced high at cycle 2.
  - Debounced high at cycle 2+DEBOUNCE_CYCLES.
  - accepted pulse and pending increment visible at cycle 3+DEBOUNCE_CYCLES.
  - direction changes at the first tick edge after that.
- Release also goes through the debounce but generates no event.
- pending never exceeds QUEUE_DEPTH.
- FIFO pointers wrap modulo QUEUE_DEPTH, which need not be a power of two.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package dir_pkg:
  - One-hot constants DIR_UP=4'b1000, DIR_DOWN=4'b0100, DIR_LEFT=4'b0010, DIR_RIGHT=4'b0001.
  - Function dir_reverse(N_BTN-bit vector) returning the pair-swapped vector.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES): one instance per button in a generate loop.
  - Ports: clk, rst, raw_in, level_out, rise_pulse.
  - Contains the synchroniser, counter and edge register.
- Arbiter, reversal filter and FIFO stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, INIT_DIR=DIR_RIGHT):
1. Reset, then idle 20 cycles with ticks → direction=0001, pending=0, no pulses.
2. Press up (btn=1000), held from cycle 0 → accepted at cycle 7, pending=1. Next tick → direction=1000, pending=0.
3. Bounce: btn[3] high 3 cycles, low 1 cycle, repeated 5 times → no accepted pulse, pending=0.
4. Direction=0001, press left (0010) → rejected pulse, pending=0. Press right (0001) → rejected pulse.
5. Direction=0001, press up, down, left in sequence with no tick:
   - up → accepted, pending=1.
   - down → rejected (reverse of tail 1000).
   - left → accepted, pending=2.
   - Then press down → overflow, pending=2.
   - Two ticks → direction becomes 1000, then 0010.
6. pending=2 (tails up, left), press down debouncing on the same edge as tick → accepted, pending=2, direction=1000, FIFO holds left, down. Assert rst with the FIFO non-empty → next cycle direction=0001, pending=0.
